// File: rtl/msk_inv_pipe.sv
// Elastic masked bitwise-inversion pipeline: inverts share 0 of each element
// selected by in_inv and carries sharings through LAT valid/ready stages.
// Ports: clk, rst_n (async, active-low); in_data/in_inv/in_valid/in_ready,
// rnd (only with MSK_INV_REFRESH_EN), out_data/out_valid/out_ready, occ.
// Optional feature macro: MSK_INV_REFRESH_EN (share refresh on entry).
module msk_inv_pipe #(
    parameter int d     = 2,
    parameter int count = 1,
    parameter int LAT   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [count*d-1:0]       in_data,
    input  logic [count-1:0]         in_inv,
    input  logic                     in_valid,
    output logic                     in_ready,
`ifdef MSK_INV_REFRESH_EN
    input  logic [count*(d-1)-1:0]   rnd,
`endif
    output logic [count*d-1:0]       out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(LAT+1)-1:0] occ
);

    localparam int W  = count * d;
    localparam int OW = $clog2(LAT + 1);

    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("msk_inv_pipe: LAT must be in 1..4");
    end
    if (d < 1 || count < 1) begin : g_bad_dim
        $error("msk_inv_pipe: d and count must be >= 1");
    end
`ifdef MSK_INV_REFRESH_EN
    if (d < 2) begin : g_bad_refresh
        $error("msk_inv_pipe: refresh needs d >= 2");
    end
`endif

    logic [LAT-1:0] v_q, v_d;
    logic [LAT-1:0] adv;
    logic [LAT-1:0] wr;
    logic [W-1:0]   data_q [LAT];
    logic [W-1:0]   data_d [LAT];
    logic [W-1:0]   xform;
    logic [OW-1:0]  occ_q, occ_d;
    logic           in_fire;
    logic           out_fire;

    // Ready chain walks back from out_ready; "free" means the stage
    // downstream of k is empty or moving this cycle.
    always_comb begin
        logic free;
        adv  = '0;
        free = out_ready;
        for (int k = LAT - 1; k >= 0; k--) begin
            adv[k] = v_q[k] & free;
            free   = ~v_q[k] | adv[k];
        end
        in_ready = free;
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = adv[LAT-1];

    always_comb begin
        wr    = '0;
        wr[0] = in_fire;
        for (int k = 1; k < LAT; k++) begin
            wr[k] = adv[k-1];
        end
    end

    // Entry transform: only share 0 is touched by the inversion.
    always_comb begin
        xform = in_data;
        for (int i = 0; i < count; i++) begin
            xform[i*d] = in_data[i*d] ^ in_inv[i];
`ifdef MSK_INV_REFRESH_EN
            begin
                logic mix;
                mix = 1'b0;
                for (int j = 1; j < d; j++) begin
                    xform[i*d+j] = in_data[i*d+j] ^ rnd[i*(d-1)+j-1];
                    mix          = mix ^ rnd[i*(d-1)+j-1];
                end
                xform[i*d] = xform[i*d] ^ mix;
            end
`endif
        end
    end

    always_comb begin
        v_d       = (v_q & ~adv) | wr;
        data_d[0] = wr[0] ? xform : data_q[0];
        for (int k = 1; k < LAT; k++) begin
            data_d[k] = wr[k] ? data_q[k-1] : data_q[k];
        end
    end

    always_comb begin
        case ({in_fire, out_fire})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int k = 0; k < LAT; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_data  = data_q[LAT-1];
    assign out_valid = v_q[LAT-1];
    assign occ       = occ_q;

endmodule

// File: tb/tb_msk_inv_pipe.sv
// Bench for msk_inv_pipe: directed vectors on a d=2/LAT=1 instance and a
// queue-model scoreboard on a d=3/count=4/LAT=3 instance.
module tb_msk_inv_pipe;

    localparam int LB = 3;

    logic clk;
    logic rst_n;

    int ntests = 0;
    int nfail  = 0;

    // Instance A: d=2, count=1, LAT=1
    logic [1:0] a_in_data;
    logic [0:0] a_inv;
    logic [0:0] a_rnd;
    logic       a_in_valid, a_in_ready;
    logic [1:0] a_out_data;
    logic       a_out_valid, a_out_ready;
    logic [0:0] a_occ;

    // Instance B: d=3, count=4, LAT=3
    logic [11:0] b_in_data;
    logic [3:0]  b_inv;
    logic [7:0]  b_rnd;
    logic        b_in_valid, b_in_ready;
    logic [11:0] b_out_data;
    logic        b_out_valid, b_out_ready;
    logic [1:0]  b_occ;

    msk_inv_pipe #(.d(2), .count(1), .LAT(1)) u_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (a_in_data),
        .in_inv   (a_inv),
        .in_valid (a_in_valid),
        .in_ready (a_in_ready),
`ifdef MSK_INV_REFRESH_EN
        .rnd      (a_rnd),
`endif
        .out_data (a_out_data),
        .out_valid(a_out_valid),
        .out_ready(a_out_ready),
        .occ      (a_occ)
    );

    msk_inv_pipe #(.d(3), .count(4), .LAT(LB)) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (b_in_data),
        .in_inv   (b_inv),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
`ifdef MSK_INV_REFRESH_EN
        .rnd      (b_rnd),
`endif
        .out_data (b_out_data),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .occ      (b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] din;
        logic [3:0]  inv;
        logic [11:0] exp;
    } item_t;

    item_t q[$];

    // Unmasked value of each element: XOR over its three shares.
    function automatic logic [3:0] unmask(input logic [11:0] x);
        logic [3:0] u;
        for (int i = 0; i < 4; i++) u[i] = x[i*3] ^ x[i*3+1] ^ x[i*3+2];
        return u;
    endfunction

    function automatic logic [11:0] expect_out(input logic [11:0] din,
                                               input logic [3:0] inv,
                                               input logic [7:0] r);
        logic [11:0] o;
        o = din;
        for (int i = 0; i < 4; i++) begin
            o[i*3] = o[i*3] ^ inv[i];
`ifdef MSK_INV_REFRESH_EN
            o[i*3+1] = o[i*3+1] ^ r[i*2];
            o[i*3+2] = o[i*3+2] ^ r[i*2+1];
            o[i*3]   = o[i*3] ^ r[i*2] ^ r[i*2+1];
`endif
        end
        return o;
    endfunction

    // One cycle on instance B; want_ov < 0 skips the exact out_valid check.
    task automatic b_cycle(input logic iv, input logic ordy, input int want_ov);
        logic  in_f, out_f;
        item_t it;
        @(negedge clk);
        b_in_data   = 12'($urandom);
        b_inv       = 4'($urandom);
        b_rnd       = 8'($urandom);
        b_in_valid  = iv;
        b_out_ready = ordy;
        #1;
        check("b_in_ready", b_in_ready, (q.size() < LB) || ordy);
        check("b_occ", b_occ, q.size());
        if (q.size() == 0) check("b_out_valid_empty", b_out_valid, 0);
        if (want_ov >= 0) check("b_out_valid_stream", b_out_valid, want_ov);
        in_f  = iv & b_in_ready;
        out_f = b_out_valid & ordy;
        if (out_f && q.size() > 0) begin
            check("b_out_data", b_out_data, q[0].exp);
            check("b_unmasked", unmask(b_out_data), unmask(q[0].din) ^ q[0].inv);
        end
        it.din = b_in_data;
        it.inv = b_inv;
        it.exp = expect_out(b_in_data, b_inv, b_rnd);
        @(posedge clk);
        if (out_f && q.size() > 0) void'(q.pop_front());
        if (in_f) q.push_back(it);
    endtask

    typedef struct {
        logic [1:0] din;
        logic       inv;
        logic       rnd;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs[4];
    logic [11:0] held;

    initial begin
`ifdef MSK_INV_REFRESH_EN
        vecs[0] = '{din: 2'b10, inv: 1'b0, rnd: 1'b1, exp: 2'b01};
        vecs[1] = '{din: 2'b01, inv: 1'b1, rnd: 1'b0, exp: 2'b00};
        vecs[2] = '{din: 2'b11, inv: 1'b1, rnd: 1'b1, exp: 2'b01};
        vecs[3] = '{din: 2'b00, inv: 1'b0, rnd: 1'b0, exp: 2'b00};
`else
        vecs[0] = '{din: 2'b01, inv: 1'b1, rnd: 1'b0, exp: 2'b00};
        vecs[1] = '{din: 2'b01, inv: 1'b0, rnd: 1'b1, exp: 2'b01};
        vecs[2] = '{din: 2'b10, inv: 1'b1, rnd: 1'b1, exp: 2'b11};
        vecs[3] = '{din: 2'b11, inv: 1'b1, rnd: 1'b0, exp: 2'b10};
`endif
        rst_n       = 1'b0;
        a_in_data   = '0;
        a_inv       = '0;
        a_rnd       = '0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        b_in_data   = '0;
        b_inv       = '0;
        b_rnd       = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", b_out_valid, 0);
        check("rst_out_data", b_out_data, 0);
        check("rst_occ", b_occ, 0);
        check("rst_in_ready", b_in_ready, 1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("idle_out_valid", b_out_valid, 0);
        check("idle_out_data", b_out_data, 0);
        check("idle_occ", b_occ, 0);
        check("idle_in_ready", b_in_ready, 1);
        check("idle_a_out_valid", a_out_valid, 0);

        // Directed vectors, LAT=1: result visible one edge after accept.
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            a_in_data   = vecs[n].din;
            a_inv       = vecs[n].inv;
            a_rnd       = vecs[n].rnd;
            a_in_valid  = 1'b1;
            a_out_ready = 1'b1;
            #1;
            check("a_no_bypass", a_out_valid, 0);
            check("a_in_ready", a_in_ready, 1);
            @(negedge clk);
            a_in_valid = 1'b0;
            #1;
            check("a_out_valid", a_out_valid, 1);
            check("a_out_data", a_out_data, vecs[n].exp);
            check("a_occ", a_occ, 1);
        end
        // Inputs without an accepted transfer must not disturb held data.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            a_rnd     = ~a_rnd;
            a_inv     = ~a_inv;
            a_in_data = ~a_in_data;
            #1;
            check("a_hold_data", a_out_data, vecs[3].exp);
            check("a_hold_valid", a_out_valid, 0);
        end

        // Full-rate stream.
        for (int c = 0; c < 100; c++) b_cycle(1'b1, 1'b1, (c >= LB) ? 1 : 0);
        repeat (LB + 2) b_cycle(1'b0, 1'b1, -1);
        check("b_drain_stream", q.size(), 0);

        // Random valid/ready.
        repeat (200) b_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        repeat (2 * LB + 2) b_cycle(1'b0, 1'b1, -1);
        check("b_drain_random", q.size(), 0);

        // Backpressure: fill, hold, then pass-through at full occupancy.
        repeat (LB) b_cycle(1'b1, 1'b0, -1);
        b_cycle(1'b1, 1'b0, -1);
        #1 held = b_out_data;
        check("bp_occ_full", b_occ, LB);
        check("bp_in_ready", b_in_ready, 0);
        repeat (3) begin
            b_cycle(1'b1, 1'b0, -1);
            #1;
            check("bp_hold_data", b_out_data, held);
            check("bp_hold_occ", b_occ, LB);
        end
        repeat (5) begin
            b_cycle(1'b1, 1'b1, 1);
            #1 check("bp_pass_occ", b_occ, LB);
        end
        repeat (2 * LB + 2) b_cycle(1'b0, 1'b1, -1);
        check("b_drain_bp", q.size(), 0);

        // Asynchronous reset with entries in flight.
        repeat (2) b_cycle(1'b1, 1'b0, -1);
        @(negedge clk);
        b_in_valid = 1'b0;
        #1 check("mid_occ_before", b_occ, 2);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", b_out_valid, 0);
        check("mid_rst_occ", b_occ, 0);
        check("mid_rst_out_data", b_out_data, 0);
        check("mid_rst_in_ready", b_in_ready, 1);
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (LB + 2) b_cycle(1'b0, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/msk_inv_pipe.md
# msk_inv_pipe

Pipelined, elastic masked bitwise-inversion gadget: applies a per-element runtime inversion mask to `count` Boolean-masked bits of `d` shares each, carrying them through `LAT` register stages with valid/ready flow control. Successor to the combinational masked NOT gate. It is used where inverted sharings must cross a register boundary, for example in the S-box affine layer and the key-schedule datapath. Optionally it refreshes the sharing on entry.

## Interface
- `d`, default 2: number of shares per bit (≥1; ≥2 when refresh is enabled).
- `count`, default 1: number of masked bits (elements) per transfer.
- `LAT`, default 1: pipeline depth in register stages, legal range 1..4.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in `count*d`: input sharings; bit `i*d+j` is share `j` of element `i`.
- `in_inv` in `count`: element `i` is inverted when `in_inv[i]`=1; public, unmasked.
- `in_valid` in 1: input transfer offered.
- `in_ready` out 1: input transfer accepted this cycle.
- `rnd` in `count*(d-1)`: fresh randomness. Present only with `MSK_INV_REFRESH_EN`.
- `out_data` out `count*d`: output sharings, same layout as `in_data`.
- `out_valid` out 1: output transfer offered.
- `out_ready` in 1: downstream accepts.
- `occ` out `$clog2(LAT+1)`: number of occupied pipeline stages.

## Operation
- Transfer on an input or output port: `valid & ready` high at a rising `clk` edge.
- Stage 0 captures the transformed input. Share 0 of element `i` is `in_data[i*d] ^ in_inv[i]`. Shares 1..d-1 pass unchanged.
- Only share 0 is ever inverted. No cross-share combinational logic exists other than the refresh XOR described under Configuration.
- Each stage k holds a data register and a valid bit `v[k]`.
- Stage k advances when `v[k]` is set and either stage k+1 is empty or stage k+1 advances. The last stage advances on `out_ready`.
- `in_ready = ~v[0] | adv[0]`, which gives bubble-collapsing behaviour. The ready chain is combinational from `out_ready`.
- `out_data` and `out_valid` are driven directly from the last-stage registers.
- `occ` is the popcount of `v`, registered as a counter: +1 on an accepted input, -1 on an accepted output, unchanged when both occur.
- A stage's data register loads only when that stage is written. Data is held while stalled.
- Reset, asserted at any time (including mid-transfer): all `v` clear, all data registers clear to 0, and `occ`=0, all asynchronously. Pending contents are discarded. No transfer completes on the edge on which reset releases.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `occ`=0, `in_ready`=1 (when `rst_n` is high and the pipe is empty).
- Latency: an input accepted at edge n is presented on `out_data` after edge n+LAT-1, and can complete at edge n+LAT if `out_ready` is high.
- Throughput: one transfer per cycle with `out_ready` held high.
- Full (`occ`=LAT) with `out_ready`=0: `in_ready`=0 and all registers hold.
- Full with `out_ready`=1: simultaneous input and output transfers; `occ` stays at LAT.
- Empty: `out_valid`=0 and `occ`=0. There is no combinational bypass, even for `LAT`=1.

## Configuration
- `MSK_INV_REFRESH_EN` defined:
  - The `rnd` port exists and is sampled only on an accepted input.
  - Stage 0 applies a refresh: share `j`≥1 of element `i` ^= `rnd[i*(d-1)+j-1]`, and share 0 ^= the XOR of those `d-1` bits, in addition to inversion.
  - The unmasked value is unchanged.
  - Elaboration fails if `d`<2.
- Undefined: no `rnd` port. Shares are passed as-is apart from the share-0 inversion.

## Test plan
- Reset, then check the idle state: during reset and after release, `out_valid`=0, `out_data`=0, `occ`=0, `in_ready`=1.
- `d`=2, `count`=1, `LAT`=1, no refresh: input `in_data`=2'b01, `in_inv`=1, `out_ready`=1. Next cycle `out_data`=2'b00 (unmasked 0), `out_valid`=1.
- `d`=3, `count`=4, `LAT`=3: stream 100 random sharings with random `in_inv` and `out_ready` held at 1.
  - One output per cycle after a 3-cycle fill.
  - Unmasked output = unmasked input ^ `in_inv`, with share 0 only differing from the input shares.
- Backpressure, `LAT`=2: fill 2 entries with `out_ready`=0.
  - `occ`=2, `in_ready`=0, and `out_data` is stable.
  - Raise `out_ready` while `in_valid`=1: one in and one out per cycle, `occ` stays 2.
- Reset mid-stream, `LAT`=4 with `occ`=3: assert `rst_n`=0 asynchronously, between edges.
  - `out_valid` and `occ` are 0 immediately.
  - No stale data appears after release.
- `MSK_INV_REFRESH_EN` with `d`=2: `in_data`=2'b10, `in_inv`=0, `rnd`=1.
  - Output shares are 2'b01, i.e. unmasked 1, with both shares flipped.
  - `rnd` is ignored on cycles with no accepted input.
